ofs_plat_prim_almfull_sink_fifo: RTL and testbench
==================================================

// Module: ofs_plat_prim_almfull_sink_fifo
//
// PURPOSE
//  Sink-end receiver for the almost-full ready protocol used by simple AXI MM register stages.
//  - Upstream drives request beats on enq_valid without checking ready.
//  - Beats already in flight after ready drops must still be absorbed: up to N_SLACK beats
//    (register stages plus ready-return stages).
//  - The block buffers request beats and re-issues them downstream with a normal
//    valid/ready handshake.
//  - One instance is used per request channel (AW, W or AR) at the memory-side end of a
//    registered pipeline.
//
// PARAMETERS
//  N_DATA_BITS  64  width of one request beat (packed channel payload)
//  N_ENTRIES    16  buffer depth; power of 2, >= 2
//  N_SLACK      4   beats upstream may still send after ready deasserts; 0 < N_SLACK < N_ENTRIES
//
// PORTS
//  clk            in   1                         clock
//  reset_n        in   1                         async active-low reset
//  enq_valid      in   1                         beat present; already qualified upstream, never backpressured
//  enq_data       in   N_DATA_BITS               beat payload
//  almfull_ready  out  1                         registered ready returned to upstream ready pipeline
//  deq_valid      out  1                         buffered beat available (first-word fall-through)
//  deq_data       out  N_DATA_BITS               head beat payload
//  deq_ready      in   1                         downstream accepts head beat
//  count          out  $clog2(N_ENTRIES+1)       current occupancy
//  overflow_err   out  1                         sticky: a beat arrived while full and was dropped
//
// BEHAVIOUR
//  - Reset (async assert, sync release) forces:
//    - count=0, rd/wr pointers=0
//    - almfull_ready=0, deq_valid=0, overflow_err=0
//    - deq_data is don't-care
//  - almfull_ready is rising 0 -> 1 on the first clk edge after reset_n deasserts.
//  - Enqueue:
//    - Every cycle with enq_valid=1, enq_data is written at wr_ptr and wr_ptr increments,
//      unless the buffer is full with no same-cycle dequeue.
//    - almfull_ready is not consulted for enqueue.
//  - Dequeue: deq = deq_valid && deq_ready; rd_ptr increments.
//  - Pointers: $clog2(N_ENTRIES) bits, wrap modulo N_ENTRIES.
//  - count: full/empty is decided from count, not from pointer compare.
//  - count_next = count + enq_accepted - deq (stays within 0..N_ENTRIES).
//  - Enqueue-to-deq_valid latency: 1 cycle. A beat written at edge k is visible on deq_data after edge k.
//  - deq_valid = (count != 0). deq_data = mem[rd_ptr] combinationally.
//  - almfull_ready <= ((N_ENTRIES - count_next) > N_SLACK). Registered with zero extra lag,
//    so it is low in the same cycle count first reads N_ENTRIES-N_SLACK.
//  - Full + enq_valid + deq in the same cycle:
//    - the beat is accepted
//    - count stays N_ENTRIES
//    - no overflow
//  - Full + enq_valid + no deq:
//    - the beat is dropped, pointers unchanged
//    - overflow_err <= 1, which holds until reset
//    - this is a protocol violation upstream; also flagged by a simulation-only $error
//  - Empty + deq_ready: no effect.
//  - enq into empty with deq_ready=1: no bypass; the beat emerges on the next cycle.
//  - Reset asserted mid-traffic:
//    - all state clears immediately
//    - in-flight beats are lost
//    - almfull_ready=0 blocks new traffic until reset release
//  - Simulation-only checks: deq_data is not X when deq_valid=1; parameter legality.
//
// TESTING
//  - Reset: assert reset_n=0 with count=7 -> same cycle count=0, deq_valid=0, almfull_ready=0.
//    First edge after release -> almfull_ready=1.
//  - Almost-full threshold (16/4 config), deq_ready=0, back-to-back enq:
//    - almfull_ready drops when count=12
//    - 4 further beats accepted -> count=16, overflow_err=0
//  - Overflow: 17th beat with deq_ready=0 -> dropped, count=16, overflow_err=1.
//    It stays 1 after draining until reset.
//  - Full + simultaneous enq/deq every cycle for 20 cycles:
//    - count stays 16, overflow_err=0
//    - output order matches input order
//  - Streaming, enq_valid=deq_ready=1 continuously:
//    - count=1 steady state
//    - almfull_ready stays 1
//    - data values 0..99 emerge in order with 1-cycle latency
//  - Wrap-around with random deq_ready (50%):
//    - 1000 incrementing beats, upstream obeys ready with 4-cycle delayed reaction
//    - all beats in order, overflow_err=0

Source files
------------

// File: rtl/ofs_plat_prim_almfull_sink_fifo_if.sv
// Handshake bundle for the almost-full sink FIFO.
// It carries the upstream enqueue beats, the ready return, the downstream dequeue and the status outputs.
interface ofs_plat_prim_almfull_sink_fifo_if #(
  parameter int N_DATA_BITS = 64,
  parameter int N_ENTRIES   = 16
);
  localparam int CNT_W = $clog2(N_ENTRIES + 1);

  logic                   enq_valid;
  logic [N_DATA_BITS-1:0] enq_data;
  logic                   almfull_ready;
  logic                   deq_valid;
  logic [N_DATA_BITS-1:0] deq_data;
  logic                   deq_ready;
  logic [CNT_W-1:0]       count;
  logic                   overflow_err;

  modport master (
    output enq_valid, enq_data, deq_ready,
    input  almfull_ready, deq_valid, deq_data, count, overflow_err
  );

  modport slave (
    input  enq_valid, enq_data, deq_ready,
    output almfull_ready, deq_valid, deq_data, count, overflow_err
  );
endinterface

// File: rtl/ofs_plat_prim_almfull_sink_fifo.sv
// Sink-end buffer for the almost-full ready protocol. It absorbs beats that upstream sends
// without backpressure and re-issues them through a first-word fall-through valid/ready port.
module ofs_plat_prim_almfull_sink_fifo #(
  parameter int N_DATA_BITS        = 64,
  parameter int N_ENTRIES          = 16,
  parameter int N_SLACK            = 4,
  parameter bit SIM_CHECK_OVERFLOW = 1'b1
) (
  input logic clk,
  input logic reset_n,
  ofs_plat_prim_almfull_sink_fifo_if.slave fifo
);
  localparam int PTR_W = $clog2(N_ENTRIES);
  localparam int CNT_W = $clog2(N_ENTRIES + 1);
  localparam logic [CNT_W-1:0] DEPTH       = CNT_W'(N_ENTRIES);
  localparam logic [CNT_W-1:0] READY_LIMIT = CNT_W'(N_ENTRIES - N_SLACK);

  logic [N_DATA_BITS-1:0] mem [N_ENTRIES];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       count;
  logic [CNT_W-1:0]       count_next;
  logic                   almfull_ready;
  logic                   overflow_err;
  logic                   empty;
  logic                   full;
  logic                   deq;
  logic                   enq_accepted;
  logic                   enq_dropped;

  // Full and empty come from count alone, so the pointers never need an extra wrap bit.
  assign empty        = (count == '0);
  assign full         = (count == DEPTH);
  assign deq          = !empty && fifo.deq_ready;
  assign enq_accepted = fifo.enq_valid && (!full || deq);
  assign enq_dropped  = fifo.enq_valid && full && !deq;

  always_comb begin
    count_next = count;
    case ({enq_accepted, deq})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  // Ready is computed from next-state occupancy, so it drops in the same cycle
  // that count first reaches the slack threshold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      almfull_ready <= 1'b0;
      overflow_err  <= 1'b0;
    end else begin
      if (enq_accepted) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq)          rd_ptr <= rd_ptr + PTR_W'(1);
      count         <= count_next;
      almfull_ready <= (count_next < READY_LIMIT);
      if (enq_dropped) overflow_err <= 1'b1;
    end
  end

  // Storage is not reset; entries are only read after they have been written.
  always_ff @(posedge clk) begin
    if (enq_accepted) mem[wr_ptr] <= fifo.enq_data;
  end

  assign fifo.deq_valid     = !empty;
  assign fifo.deq_data      = mem[rd_ptr];
  assign fifo.count         = count;
  assign fifo.almfull_ready = almfull_ready;
  assign fifo.overflow_err  = overflow_err;

  if (N_ENTRIES < 2 || (N_ENTRIES & (N_ENTRIES - 1)) != 0) begin : g_bad_depth
    $error("N_ENTRIES must be a power of 2 and at least 2");
  end
  if (N_SLACK <= 0 || N_SLACK >= N_ENTRIES) begin : g_bad_slack
    $error("N_SLACK must satisfy 0 < N_SLACK < N_ENTRIES");
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (reset_n) begin
      if (SIM_CHECK_OVERFLOW && enq_dropped)
        $error("%m: beat dropped, enq_valid while full with no dequeue");
      assert (!(fifo.deq_valid && $isunknown(fifo.deq_data)))
        else $error("%m: deq_data unknown while deq_valid is high");
    end
  end
`endif
endmodule

// File: tb/tb_ofs_plat_prim_almfull_sink_fifo.sv
// Bench for the almost-full sink FIFO. A queue-based model supplies the expected values.
// The stimulus is directed, with random downstream ready.
module tb_ofs_plat_prim_almfull_sink_fifo;
  localparam int N_DATA_BITS = 64;
  localparam int N_ENTRIES   = 16;
  localparam int N_SLACK     = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int n_cmp = 0;
  int n_mis = 0;

  logic [63:0] mq[$];
  bit          m_rdy = 1'b0;
  bit          m_ovf = 1'b0;
  bit          got_pop;
  logic [63:0] pop_val;
  bit          rdy_hist[5];
  int          sent;
  int          rcvd;
  int          cyc;
  logic [63:0] exp_v;

  ofs_plat_prim_almfull_sink_fifo_if #(.N_DATA_BITS(N_DATA_BITS), .N_ENTRIES(N_ENTRIES)) fifo_if ();

  ofs_plat_prim_almfull_sink_fifo #(
    .N_DATA_BITS(N_DATA_BITS),
    .N_ENTRIES(N_ENTRIES),
    .N_SLACK(N_SLACK),
    .SIM_CHECK_OVERFLOW(1'b0)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .fifo(fifo_if)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    chk("count", 64'(fifo_if.count), 64'(mq.size()));
    chk("deq_valid", 64'(fifo_if.deq_valid), 64'(mq.size() != 0));
    if (mq.size() != 0) chk("deq_data", fifo_if.deq_data, mq[0]);
    chk("almfull_ready", 64'(fifo_if.almfull_ready), 64'(m_rdy));
    chk("overflow_err", 64'(fifo_if.overflow_err), 64'(m_ovf));
  endtask

  // One clock: check current outputs, advance the model by the same edge, settle at negedge.
  task automatic step();
    bit deq;
    bit acc;
    check_state();
    deq = (mq.size() != 0) && fifo_if.deq_ready;
    acc = fifo_if.enq_valid && ((mq.size() < N_ENTRIES) || deq);
    got_pop = deq;
    if (deq) pop_val = mq.pop_front();
    if (acc) mq.push_back(fifo_if.enq_data);
    else if (fifo_if.enq_valid) m_ovf = 1'b1;
    m_rdy = (N_ENTRIES - mq.size()) > N_SLACK;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    mq.delete();
    m_rdy = 1'b0;
    m_ovf = 1'b0;
    #1;
    chk("rst_count", 64'(fifo_if.count), 64'd0);
    chk("rst_deq_valid", 64'(fifo_if.deq_valid), 64'd0);
    chk("rst_ready", 64'(fifo_if.almfull_ready), 64'd0);
    chk("rst_ovf", 64'(fifo_if.overflow_err), 64'd0);
    repeat (2) @(negedge clk);
    check_state();
    reset_n = 1'b1;
  endtask

  initial begin
    fifo_if.enq_valid = 1'b0;
    fifo_if.enq_data  = '0;
    fifo_if.deq_ready = 1'b0;
    @(negedge clk);
    do_reset();
    chk("rdy_before_first_edge", 64'(fifo_if.almfull_ready), 64'd0);
    step();
    chk("rdy_first_edge", 64'(fifo_if.almfull_ready), 64'd1);

    // Almost-full threshold, then overflow
    fifo_if.deq_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      fifo_if.enq_valid = 1'b1;
      fifo_if.enq_data  = 64'(32'h1000 + i);
      step();
      if (i == 10) chk("thr_rdy_at_11", 64'(fifo_if.almfull_ready), 64'd1);
      if (i == 11) begin
        chk("thr_count_12", 64'(fifo_if.count), 64'd12);
        chk("thr_rdy_at_12", 64'(fifo_if.almfull_ready), 64'd0);
      end
    end
    chk("thr_count_16", 64'(fifo_if.count), 64'd16);
    chk("thr_ovf_clear", 64'(fifo_if.overflow_err), 64'd0);
    fifo_if.enq_data = 64'hdead_beef;
    step();
    fifo_if.enq_valid = 1'b0;
    chk("ovf_count", 64'(fifo_if.count), 64'd16);
    chk("ovf_flag", 64'(fifo_if.overflow_err), 64'd1);

    fifo_if.deq_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("drain_order", pop_val, 64'(32'h1000 + i));
    end
    step();
    chk("drain_count", 64'(fifo_if.count), 64'd0);
    chk("ovf_sticky", 64'(fifo_if.overflow_err), 64'd1);

    // Reset while holding 7 beats
    fifo_if.deq_ready = 1'b0;
    fifo_if.enq_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      fifo_if.enq_data = 64'(32'h5000 + i);
      step();
    end
    fifo_if.enq_valid = 1'b0;
    chk("pre_rst_count_7", 64'(fifo_if.count), 64'd7);
    do_reset();
    step();
    chk("post_rst_ready", 64'(fifo_if.almfull_ready), 64'd1);
    chk("post_rst_ovf", 64'(fifo_if.overflow_err), 64'd0);

    // Full with simultaneous enqueue and dequeue
    fifo_if.enq_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      fifo_if.enq_data = 64'(32'h2000 + i);
      step();
    end
    fifo_if.deq_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      fifo_if.enq_data = 64'(32'h3000 + i);
      step();
      exp_v = (i < 16) ? 64'(32'h2000 + i) : 64'(32'h3000 + i - 16);
      chk("full_count", 64'(fifo_if.count), 64'd16);
      chk("full_ovf", 64'(fifo_if.overflow_err), 64'd0);
      chk("full_order", pop_val, exp_v);
    end
    fifo_if.enq_valid = 1'b0;
    for (int i = 0; i < 16; i++) step();
    chk("full_drained", 64'(fifo_if.count), 64'd0);

    // Streaming 0..99
    fifo_if.deq_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      fifo_if.enq_valid = 1'b1;
      fifo_if.enq_data  = 64'(i);
      if (i == 0) chk("no_bypass", 64'(fifo_if.deq_valid), 64'd0);
      step();
      if (i > 0) chk("stream_order", pop_val, 64'(i - 1));
      chk("stream_count", 64'(fifo_if.count), 64'd1);
      chk("stream_ready", 64'(fifo_if.almfull_ready), 64'd1);
      chk("stream_head", fifo_if.deq_data, 64'(i));
    end
    fifo_if.enq_valid = 1'b0;
    step();
    chk("stream_last", pop_val, 64'd99);

    // Wrap-around: upstream reacts to ready four cycles late, downstream ready is random
    for (int k = 0; k < 5; k++) rdy_hist[k] = fifo_if.almfull_ready;
    sent = 0;
    rcvd = 0;
    cyc  = 0;
    while (rcvd < 1000 && cyc < 20000) begin
      fifo_if.enq_valid = rdy_hist[4] && (sent < 1000);
      fifo_if.enq_data  = 64'(sent);
      fifo_if.deq_ready = ($urandom_range(0, 1) == 1);
      if (fifo_if.enq_valid) sent++;
      step();
      if (got_pop) begin
        chk("wrap_order", pop_val, 64'(rcvd));
        rcvd++;
      end
      for (int k = 4; k > 0; k--) rdy_hist[k] = rdy_hist[k-1];
      rdy_hist[0] = fifo_if.almfull_ready;
      cyc++;
    end
    fifo_if.enq_valid = 1'b0;
    fifo_if.deq_ready = 1'b0;
    chk("wrap_all_received", 64'(rcvd), 64'd1000);
    chk("wrap_ovf", 64'(fifo_if.overflow_err), 64'd0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
